// File: rtl/align_buffer.sv
// Align buffer between fetch and decode: a circular halfword queue fed by fetch blocks,
// split into RVC and 32-bit instructions and presented as up to ISSUE_WIDTH slots per cycle.

package align_buffer_pkg;
  typedef struct packed {
    logic       valid;
    logic [3:0] cause;
  } except_t;
endpackage

module align_buffer
  import align_buffer_pkg::*;
#(
  parameter int FETCH_HALVES = 4,
  parameter int ISSUE_WIDTH  = 2,
  parameter int BUF_HALVES   = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_valid,
  input  logic [31:0]                  i_pc,
  input  logic [16*FETCH_HALVES-1:0]   i_data,
  input  except_t                      i_except,
  output logic                         o_ready,
  output logic [ISSUE_WIDTH-1:0]       o_valid,
  output logic [32*ISSUE_WIDTH-1:0]    o_pc,
  output logic [32*ISSUE_WIDTH-1:0]    o_instr,
  output logic [ISSUE_WIDTH-1:0]       o_short,
  output except_t [ISSUE_WIDTH-1:0]    o_except,
  input  logic                         i_ready
);

  localparam int AW = $clog2(BUF_HALVES);
  localparam int CW = AW + 1;
  localparam int FL = $clog2(FETCH_HALVES);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [15:0]   half_q [BUF_HALVES];
  logic [31:0]   pc_q   [BUF_HALVES];
  except_t       exc_q  [BUF_HALVES];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [FL-1:0] startIdx;
  logic [31:0]   pcBase;
  logic [CW-1:0] appended;
  logic [CW-1:0] consumed;
  logic          doEnq;
  logic          doDeq;
  logic          unusedPcBit;
  logic [AW-1:0] wrIdx [FETCH_HALVES];

  logic [CW-1:0] off;
  logic [CW-1:0] remaining;
  logic [AW-1:0] rdIdx;
  logic [AW-1:0] rdIdxNext;
  logic          stop;

  assign startIdx    = i_pc[FL:1];
  assign pcBase      = {i_pc[31:FL+1], {(FL+1){1'b0}}};
  assign appended    = CW'(FETCH_HALVES) - CW'(startIdx);
  assign unusedPcBit = i_pc[0];

  // Free space comes from the registered count only, so a same-cycle drain never opens room.
  assign o_ready = (CW'(BUF_HALVES) - count_q) >= CW'(FETCH_HALVES);
  assign doEnq   = i_valid & o_ready & ~i_rst & ~i_flush;
  assign doDeq   = i_ready & o_valid[0];

  always_comb begin
    for (int j = 0; j < FETCH_HALVES; j++) begin
      wrIdx[j] = tail_q + AW'(j) - AW'(startIdx);
    end
  end

  always_ff @(posedge i_clk) begin
    if (doEnq) begin
      for (int j = 0; j < FETCH_HALVES; j++) begin
        if (j >= int'(startIdx)) begin
          half_q[wrIdx[j]] <= i_data[16*j +: 16];
          pc_q[wrIdx[j]]   <= pcBase + 32'(2*j);
          exc_q[wrIdx[j]]  <= i_except;
        end
      end
    end
  end

  // Walk the queue from head; a faulting half is always issued alone so the fault is not held back.
  always_comb begin
    o_valid   = '0;
    o_pc      = '0;
    o_short   = '0;
    o_except  = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      o_instr[32*k +: 32] = NOP_INSTR;
    end
    off       = '0;
    remaining = '0;
    rdIdx     = '0;
    rdIdxNext = '0;
    stop      = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      remaining = count_q - off;
      rdIdx     = head_q + off[AW-1:0];
      rdIdxNext = rdIdx + AW'(1);
      if (!stop) begin
        if (remaining == '0) begin
          stop = 1'b1;
        end else if (exc_q[rdIdx].valid || half_q[rdIdx][1:0] != 2'b11) begin
          o_valid[k]          = 1'b1;
          o_pc[32*k +: 32]    = pc_q[rdIdx];
          o_instr[32*k +: 32] = {16'h0000, half_q[rdIdx]};
          o_short[k]          = 1'b1;
          o_except[k]         = exc_q[rdIdx];
          off                 = off + CW'(1);
        end else if (remaining >= CW'(2)) begin
          o_valid[k]          = 1'b1;
          o_pc[32*k +: 32]    = pc_q[rdIdx];
          o_instr[32*k +: 32] = {half_q[rdIdxNext], half_q[rdIdx]};
          o_short[k]          = 1'b0;
          o_except[k]         = exc_q[rdIdxNext];
          off                 = off + CW'(2);
        end else begin
          stop = 1'b1;
        end
      end
    end
    consumed = off;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (doDeq) begin
      head_d = head_q + consumed[AW-1:0];
    end
    if (doEnq) begin
      tail_d = tail_q + appended[AW-1:0];
    end
    count_d = count_q - (doDeq ? consumed : '0) + (doEnq ? appended : '0);
    // A redirect drops everything, including a lone long low half waiting for its partner.
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifndef SYNTHESIS
  property heldBlockStable;
    @(posedge i_clk) disable iff (i_rst)
      (i_valid && $past(i_valid) && !$past(o_ready) && !$past(i_flush) && !$past(i_rst))
        |-> (i_pc == $past(i_pc) && i_data == $past(i_data));
  endproperty
  assert property (heldBlockStable);

  assert property (@(posedge i_clk) disable iff (i_rst) count_q <= CW'(BUF_HALVES));
`endif

endmodule

// File: tb/tb_align_buffer.sv
// Self-checking bench for align_buffer: a halfword-level reference model feeds a queue of
// expected instructions that is compared slot by slot against the DUT every cycle.

module tb_align_buffer;
  import align_buffer_pkg::*;

  localparam int FETCH = 4;
  localparam int ISSUE = 2;
  localparam int BUFH  = 8;

  typedef struct packed {
    logic [15:0] half;
    logic [31:0] pc;
    except_t     exc;
  } halfEntry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        isShort;
    except_t     exc;
    logic [1:0]  halves;
  } slot_t;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     flush;
  logic                     inValid;
  logic [31:0]              inPc;
  logic [16*FETCH-1:0]      inData;
  except_t                  inExcept;
  logic                     outReady;
  logic [ISSUE-1:0]         outValid;
  logic [32*ISSUE-1:0]      outPc;
  logic [32*ISSUE-1:0]      outInstr;
  logic [ISSUE-1:0]         outShort;
  except_t [ISSUE-1:0]      outExcept;
  logic                     decReady;

  halfEntry_t pendQ[$];
  slot_t      expQ[$];
  int         checks = 0;
  int         errors = 0;
  bit         primed = 1'b0;
  bit         lastAcc = 1'b0;
  bit         lastHeld = 1'b0;

  align_buffer #(
    .FETCH_HALVES(FETCH),
    .ISSUE_WIDTH (ISSUE),
    .BUF_HALVES  (BUFH)
  ) dut (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_flush  (flush),
    .i_valid  (inValid),
    .i_pc     (inPc),
    .i_data   (inData),
    .i_except (inExcept),
    .o_ready  (outReady),
    .o_valid  (outValid),
    .o_pc     (outPc),
    .o_instr  (outInstr),
    .o_short  (outShort),
    .o_except (outExcept),
    .i_ready  (decReady)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int modelCount();
    int n;
    n = pendQ.size();
    foreach (expQ[i]) n += int'(expQ[i].halves);
    return n;
  endfunction

  // Turn complete instructions at the front of the halfword stream into expected slots.
  task automatic parseModel();
    bit    done;
    slot_t s;
    done = 1'b0;
    while (!done && pendQ.size() > 0) begin
      if (pendQ[0].exc.valid || pendQ[0].half[1:0] != 2'b11) begin
        s.pc      = pendQ[0].pc;
        s.instr   = {16'h0000, pendQ[0].half};
        s.isShort = 1'b1;
        s.exc     = pendQ[0].exc;
        s.halves  = 2'd1;
        expQ.push_back(s);
        void'(pendQ.pop_front());
      end else if (pendQ.size() >= 2) begin
        s.pc      = pendQ[0].pc;
        s.instr   = {pendQ[1].half, pendQ[0].half};
        s.isShort = 1'b0;
        s.exc     = pendQ[1].exc;
        s.halves  = 2'd2;
        expQ.push_back(s);
        void'(pendQ.pop_front());
        void'(pendQ.pop_front());
      end else begin
        done = 1'b1;
      end
    end
  endtask

  task automatic modelEnqueue(input logic [31:0] pc, input logic [63:0] data, input except_t exc);
    logic [31:0] base;
    int          s;
    halfEntry_t  e;
    base = pc & ~32'(2*FETCH - 1);
    s    = int'((pc >> 1) & 32'(FETCH - 1));
    for (int j = s; j < FETCH; j++) begin
      e.half = data[16*j +: 16];
      e.pc   = base + 32'(2*j);
      e.exc  = exc;
      pendQ.push_back(e);
    end
    parseModel();
  endtask

  task automatic compareSlots(input int nVis, input logic expReady);
    checkOutput("ready", 64'(outReady), 64'(expReady));
    checkOutput("validMask", 64'(outValid), 64'((1 << nVis) - 1));
    for (int k = 0; k < nVis; k++) begin
      checkOutput($sformatf("slot%0d.pc", k), 64'(outPc[32*k +: 32]), 64'(expQ[k].pc));
      checkOutput($sformatf("slot%0d.instr", k), 64'(outInstr[32*k +: 32]), 64'(expQ[k].instr));
      checkOutput($sformatf("slot%0d.short", k), 64'(outShort[k]), 64'(expQ[k].isShort));
      checkOutput($sformatf("slot%0d.except", k), 64'(outExcept[k]), 64'(expQ[k].exc));
    end
    if (nVis < ISSUE) begin
      checkOutput("idle.instr", 64'(outInstr[32*nVis +: 32]), 64'h13);
      checkOutput("idle.pc", 64'(outPc[32*nVis +: 32]), 64'h0);
      checkOutput("idle.short", 64'(outShort[nVis]), 64'h0);
      checkOutput("idle.except", 64'(outExcept[nVis]), 64'h0);
    end
  endtask

  // One clock cycle: drive, compare against the model, clock, then advance the model.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [63:0] data,
                               input except_t exc, input logic rdy, input logic fl, input logic rs);
    int   nVis;
    logic expReady;
    bit   deq;
    inValid  = v;
    inPc     = pc;
    inData   = data;
    inExcept = exc;
    decReady = rdy;
    flush    = fl;
    reset    = rs;
    #1;
    nVis     = (expQ.size() < ISSUE) ? expQ.size() : ISSUE;
    expReady = ((BUFH - modelCount()) >= FETCH);
    if (primed) compareSlots(nVis, expReady);
    lastAcc  = primed && v && expReady && !fl && !rs;
    lastHeld = primed && v && !expReady && !fl && !rs;
    deq      = primed && rdy && (nVis > 0);
    @(posedge clock);
    #1;
    if (rs || fl) begin
      pendQ.delete();
      expQ.delete();
    end else begin
      if (deq) repeat (nVis) void'(expQ.pop_front());
      if (lastAcc) modelEnqueue(pc, data, exc);
    end
    primed = 1'b1;
  endtask

  task automatic idle(input logic rdy, input int n);
    repeat (n) applyStimulus(1'b0, 32'h0, 64'h0, '0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    except_t     noExc;
    except_t     e5;
    bit          pending;
    logic        rV;
    logic [31:0] rPc;
    logic [63:0] rData;
    except_t     rExc;
    noExc = '0;
    e5    = '{valid: 1'b1, cause: 4'd5};
    rV    = 1'b0;
    rPc   = '0;
    rData = '0;
    rExc  = '0;

    applyStimulus(1'b0, 32'h0, 64'h0, noExc, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 64'h0, noExc, 1'b0, 1'b0, 1'b1);

    // Basic split: one long then two shorts
    applyStimulus(1'b1, 32'h1000, 64'h8082_4501_0000_0013, noExc, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 3);

    // Long instruction straddling two blocks
    applyStimulus(1'b1, 32'h2006, 64'h0513_0000_0000_0000, noExc, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2);
    applyStimulus(1'b1, 32'h2008, 64'h8082_4501_0001_0000, noExc, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 4);

    // Mid-block entry drops the leading halves
    applyStimulus(1'b1, 32'h3004, 64'h8082_4501_FFFF_FFFF, noExc, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 2);

    // Faulting block: halves issue alone even when they look long
    applyStimulus(1'b1, 32'h4000, 64'h0003_0003_0003_0003, e5, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 3);

    // Backpressure: fill the queue, hold a third block, then release
    applyStimulus(1'b1, 32'h5000, 64'h4504_4503_4502_4501, noExc, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h5008, 64'h8086_8084_8082_8080, noExc, 1'b0, 1'b0, 1'b0);
    pending = 1'b1;
    for (int n = 0; n < 12 && pending; n++) begin
      applyStimulus(1'b1, 32'h5010, 64'h0000_0513_0000_0413, noExc, (n >= 3), 1'b0, 1'b0);
      if (lastAcc) pending = 1'b0;
    end
    checkOutput("blockC.accepted", 64'(pending), 64'h0);
    idle(1'b1, 8);

    // Flush with a pending long half and a simultaneous block
    applyStimulus(1'b1, 32'h6006, 64'h0513_0000_0000_0000, noExc, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1);
    applyStimulus(1'b1, 32'h7000, 64'h0000_0000_0000_0000, noExc, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1);
    applyStimulus(1'b1, 32'h7000, 64'h8082_0413_0001_4501, noExc, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 3);

    // Reset mid-operation with a pending long half
    applyStimulus(1'b1, 32'h8006, 64'h0513_0000_0000_0000, noExc, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1);
    applyStimulus(1'b1, 32'h8000, 64'h0000_0000_0000_0000, noExc, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h8000, 64'h4504_4503_4502_4501, noExc, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 3);

    // Random traffic; a block refused by o_ready is held unchanged
    for (int n = 0; n < 400; n++) begin
      if (!lastHeld) begin
        rV         = ($urandom_range(0, 3) != 0);
        rPc        = 32'h9000 + (32'($urandom_range(0, 255)) << 1);
        rData      = {$urandom, $urandom};
        rExc.valid = ($urandom_range(0, 7) == 0);
        rExc.cause = 4'($urandom_range(0, 15));
      end
      applyStimulus(rV, rPc, rData, rExc, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 39) == 0), 1'b0);
    end
    idle(1'b1, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/align_buffer.md
Name: align_buffer

Overview:
- Parametrised successor of the IF→ID align stage.
- Keeps a halfword queue fed by fetch blocks of FETCH_HALVES×16 bits.
- Splits the queue into 16-bit (RVC) and 32-bit instructions and presents up to ISSUE_WIDTH aligned raw instructions per cycle to decode, using a valid/ready handshake.
- Decompression stays downstream; this block only tags short instructions.

Parameters:
FETCH_HALVES, 4, halfwords per fetch block (power of 2, ≥2)
ISSUE_WIDTH, 2, max instructions presented per cycle (1..4)
BUF_HALVES, 8, queue depth in halfwords (power of 2, ≥ 2×FETCH_HALVES)

Ports:
i_clk  in  1  clock; all state updates on posedge
i_rst  in  1  synchronous active-high reset
i_flush  in  1  synchronous queue clear (redirect)
i_valid  in  1  fetch block valid
i_pc  in  32  PC of first useful halfword (bit 0 ignored)
i_data  in  16*FETCH_HALVES  fetch block; halfword j at bits [16j+15:16j]
i_except  in  except_t  exception attached to the whole block
o_ready  out  1  block accepted this cycle when i_valid & o_ready
o_valid  out  ISSUE_WIDTH  per-slot valid; slot k valid implies slots <k valid
o_pc  out  32*ISSUE_WIDTH  per-slot PC
o_instr  out  32*ISSUE_WIDTH  raw encoding; short instrs zero-extended in [15:0]
o_short  out  ISSUE_WIDTH  slot holds a 16-bit instruction
o_except  out  except_t*ISSUE_WIDTH  per-slot exception
i_ready  in  1  decode accepts all valid slots this cycle (all or nothing)

Behaviour:
- Queue entries: {halfword, pc, except}. Circular head/tail pointers plus a count of log2(BUF_HALVES)+1 bits. Wrap-around is natural modulo BUF_HALVES.
- Enqueue:
  - Start index s = i_pc[log2(FETCH_HALVES):1].
  - Halfwords j<s are dropped. Halfwords j=s..FETCH_HALVES-1 are appended in order.
  - Halfword j gets pc = {i_pc[31:log2(FETCH_HALVES)+1], 0s} + 2j and except = i_except.
- o_ready = (BUF_HALVES − count) ≥ FETCH_HALVES, computed from the registered count only. Same-cycle dequeue does not count toward free space.
- Slot extraction (combinational from queue head), walking k = 0..ISSUE_WIDTH-1 from cursor p (initially head):
  - If h[p].except.valid, emit a single-halfword slot: o_instr = {16'b0, h[p]}, o_short = 1, except = h[p].except. Advance 1.
  - Else if h[p][1:0] != 2'b11, emit a short slot. Advance 1.
  - Else, if 2 halves are available, emit {h[p+1], h[p]}, o_short = 0. Except = h[p+1].except (h[p]'s except is invalid here). Advance 2.
  - Else, if only h[p] remains and it is long, stop: no slot, and the half waits for the next block.
  - Stop when the queue is exhausted or k reaches ISSUE_WIDTH.
- Dequeue: when i_ready & o_valid[0], head advances by the halfwords consumed by all valid slots.
- With no valid slots, i_ready is ignored.
- Simultaneous enqueue and dequeue in one cycle: count_next = count − consumed + appended. The pointers update independently.
- o_* are combinational; latency from block acceptance to slot visibility is 1 cycle.
- i_rst or i_flush: head = tail = count = 0. All o_valid = 0 from the next cycle. A block presented in that cycle is dropped. i_flush during reset is a no-op.
- Outputs when the queue is empty: o_valid = 0, o_pc = 0, o_instr = 32'h00000013 (NOP), o_short = 0, o_except = none.
- Reset mid-operation discards partially assembled long instructions; no stale half survives.
- Assertions, checked in simulation only:
  - i_valid held without o_ready must not change i_pc/i_data.
  - count never exceeds BUF_HALVES.

Test Plan:
- Reset then block pc=0x1000, data halves {0x0013,0x0000,0x4501,0x8082} (h0..h3) -> next cycle slot0 = {pc 0x1000, instr 0x00000013, long}, slot1 = {0x1004, 0x4501, short}; after accept, slot0 = {0x1006, 0x8082, short}.
- Straddle: block pc=0x2006 with h3=0x0513 (long low half) -> no slot. Next block pc=0x2008, h0=0x0000 -> slot0 = {0x2006, 0x00000513, long}.
- Mid-block entry: pc=0x3004 -> h0,h1 dropped, count=2, first slot pc=0x3004.
- Backpressure: i_ready=0 for 3 cycles with BUF_HALVES=8, two full blocks -> o_ready=0 after 2nd block, count=8, no loss. Release -> slots drain in order.
- Exception: block pc=0x4000 with except.valid and h0=0x0003 -> slot0 = {0x4000, short=1, except valid} emitted without waiting for a second half.
- Flush with a 1-half long pending plus a simultaneous new block -> next cycle o_valid=0, count=0, no stale half combines with later input.
